// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: glyphs, digit indexing, helpers.
package seg7_pkg;

  localparam int unsigned DIG_W      = 2;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;

  // Glyphs are active-high, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

  // Slot carrying the decimal point (m0) and the leading digit (m1)
  localparam logic [DIG_W-1:0] DIG_DP = 2'd2;
  localparam logic [DIG_W-1:0] DIG_M1 = 2'd3;

  // One-hot anode pattern (active-high) for a digit index
  function automatic logic [NUM_DIGITS-1:0] dig_onehot(input logic [DIG_W-1:0] idx);
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment glyph decoder; codes 10-15 render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  // Glyph lookup
  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver showing MM.SS with frame-aligned
// shadow capture of the input digits and a per-slot anti-ghost guard interval.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the m1 digit when it is 0.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100_000,
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter bit          ACTIVE_LOW_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] m0,
  input  logic [3:0] m1,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned        CNT_W     = $clog2(SCAN_DIV);
  localparam int unsigned        SHADOW_W  = NUM_DIGITS * BCD_W;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   GUARD_LIM = CNT_W'(GUARD_CYCLES);
  localparam logic [DIG_W-1:0]   IDX_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{ACTIVE_LOW_OUT}};
  localparam logic [SEG_W-1:0]      SEG_IDLE = {SEG_W{ACTIVE_LOW_OUT}};

  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DIG_W-1:0]      idx_q,    idx_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] an_q,     an_d;
  logic [SEG_W-1:0]      seg_q,    seg_d;
  logic                  dp_q,     dp_d;

  logic                  wrap_c;
  logic                  guard_c;
  logic                  blank_c;
  logic [BCD_W-1:0]      digit_c;
  logic [SEG_W-1:0]      glyph_c;
  logic [NUM_DIGITS-1:0] an_act_c;
  logic [SEG_W-1:0]      seg_act_c;
  logic                  dp_act_c;

  assign wrap_c  = (cnt_q == CNT_LAST);
  assign guard_c = (cnt_q < GUARD_LIM);
  assign digit_c = shadow_q[{idx_q, 2'b00} +: BCD_W];

  bcd_to_seg7 u_dec (
    .bcd   (digit_c),
    .seg_c (glyph_c)
  );

  // Slot counter, digit index and frame-boundary shadow capture
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (wrap_c) begin
      cnt_d = '0;
      idx_d = idx_q + DIG_W'(1);
      if (idx_q == IDX_LAST) begin
        shadow_d = {m1, m0, s1, s0};
      end
    end
  end

  // Slot output in active-high terms, then pin polarity applied
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_c = (idx_q == DIG_M1) && (digit_c == BCD_W'(0));
`else
    blank_c = 1'b0;
`endif
    an_act_c  = '0;
    seg_act_c = SEG_OFF;
    dp_act_c  = 1'b0;
    if (!guard_c && !blank_c) begin
      an_act_c  = dig_onehot(idx_q);
      seg_act_c = glyph_c;
    end
    if (!guard_c) begin
      dp_act_c = (idx_q == DIG_DP);
    end
    an_d  = ACTIVE_LOW_OUT ? ~an_act_c  : an_act_c;
    seg_d = ACTIVE_LOW_OUT ? ~seg_act_c : seg_act_c;
    dp_d  = ACTIVE_LOW_OUT ? ~dp_act_c  : dp_act_c;
  end

  // State and output registers; reset drives every pin to its inactive level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= AN_IDLE;
      seg_q    <= SEG_IDLE;
      dp_q     <= ACTIVE_LOW_OUT;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus randomized digit changes,
// all checked every cycle against a time-based reference of the display.
module tb_seg7_scan_driver;

  localparam int unsigned SD    = 8;
  localparam int unsigned GC    = 2;
  localparam int unsigned FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] s0, s1, m0, m1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .SCAN_DIV       (SD),
    .GUARD_CYCLES   (GC),
    .ACTIVE_LOW_OUT (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s0      (s0),
    .s1      (s1),
    .m0      (m0),
    .m1      (m1),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Standard active-high glyph, {g,f,e,d,c,b,a}; non-BCD codes show a dash
  function automatic logic [6:0] ref_glyph(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 4'd9) return 7'h40;
    return tbl[d];
  endfunction

  // Expected pins {an,seg,dp} for the j-th cycle since reset, given the frame's digits
  function automatic logic [11:0] ref_out(input int unsigned j, input logic [15:0] sh);
    int unsigned pos   = j % SD;
    int unsigned slot  = (j / SD) % 4;
    logic [3:0]  d     = sh[slot*4 +: 4];
    logic [3:0]  an_hi = 4'b0001 << slot;
    logic [6:0]  g     = ref_glyph(d);
    logic        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (slot == 3) && (d == 4'd0);
`endif
    if (pos < GC) return {4'hF, 7'h7F, 1'b1};
    if (blank) return {4'hF, 7'h7F, 1'b1};
    return {~an_hi, ~g, (slot == 2) ? 1'b0 : 1'b1};
  endfunction

  // Reference: display position follows elapsed cycles; digits latched once per frame
  int unsigned edges;
  logic [15:0] ref_shadow;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edges      = 0;
      ref_shadow = '0;
      {e_an, e_seg, e_dp} = {4'hF, 7'h7F, 1'b1};
    end else begin
      edges++;
      {e_an, e_seg, e_dp} = ref_out(edges - 1, ref_shadow);
      if (edges % FRAME == 0) ref_shadow = {m1, m0, s1, s0};
    end
  end

  task automatic compare_now();
    check("an",  32'(an),  32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp",  32'(dp),  32'(e_dp));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_now();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Advance until the DUT's cycle position within a frame equals target
  task automatic wait_pos(input int unsigned lo, input int unsigned hi);
    int k = 0;
    while (!((edges % FRAME) >= lo && (edges % FRAME) <= hi) && k < 2 * FRAME) begin
      tick();
      k++;
    end
    if (k >= 2 * FRAME) check("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    {m1, m0, s1, s0} = {4'd1, 4'd2, 4'd3, 4'd4};
    #2;
    run(3);
    check("reset_an",  32'(an),  32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp",  32'(dp),  32'd1);
    reset_n = 1'b1;

    // First frame shows zeros; second shows 1234
    run(FRAME + 4);
    // Change s0 mid-frame while idx==1: invisible until next frame
    wait_pos(SD + 2, SD + 5);
    s0 = 4'd5;
    run(FRAME);
    // Invalid code on s1 shows a dash
    s1 = 4'hC;
    run(2 * FRAME);

    // Mid-frame reset at idx==2, cnt==5
    wait_pos(2 * SD + 5, 2 * SD + 5);
    #1 reset_n = 1'b0;
    #1 check("async_an",  32'(an),  32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_dp",  32'(dp),  32'd1);
    #2 reset_n = 1'b1;
    run(FRAME + 8);

    // Leading-zero case
    m1 = 4'd0;
    m0 = 4'd7;
    run(2 * FRAME);

    // Randomized digit updates at arbitrary times
    for (int i = 0; i < 40 * FRAME; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) begin
        logic [3:0] v;
        v = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: s0 = v;
          1: s1 = v;
          2: m0 = v;
          default: m1 = v;
        endcase
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
